// File: rtl/nvme_dma_axi_responder.sv
// AXI4 slave backed by a 256-bit dual-port memory that serves the NVMe SSD's bus-master traffic.
// Independent read and write paths; each completed write burst pulses wr_done for CQ-post detection.
module nvme_dma_axi_responder #(
    parameter int                 ADDR_W    = 32,
    parameter int                 DATA_W    = 256,
    parameter int                 ID_W      = 4,
    parameter int                 DEPTH     = 1024,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic                  oculink_0a_axi_aclk,
    input  logic                  oculink_0a_axi_rstn,
    input  logic [ID_W-1:0]       s_arid,
    input  logic [ADDR_W-1:0]     s_araddr,
    input  logic [7:0]            s_arlen,
    input  logic [2:0]            s_arsize,
    input  logic [1:0]            s_arburst,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [ID_W-1:0]       s_rid,
    output logic [DATA_W-1:0]     s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    input  logic [ID_W-1:0]       s_awid,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic [7:0]            s_awlen,
    input  logic [2:0]            s_awsize,
    input  logic [1:0]            s_awburst,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_wlast,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [ID_W-1:0]       s_bid,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic                  wr_done,
    output logic [ADDR_W-1:0]     wr_done_addr,
    output logic                  wr_done_err
);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(DEPTH);

    typedef enum logic {R_IDLE, R_BURST} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
        logic              last;
        logic [DATA_W-1:0] data;
    } rbeat_t;

    wire clk   = oculink_0a_axi_aclk;
    wire rst_n = oculink_0a_axi_rstn;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic addr_oor(input logic [ADDR_W-1:0] addr);
        return (addr < BASE_ADDR) || (((addr - BASE_ADDR) >> 5) >= ADDR_W'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 5);
    endfunction

    function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
        return burst[1] || (size != 3'd5);
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [1:0] burst);
        return (burst == 2'b01) ? addr + ADDR_W'(32) : addr;
    endfunction

    // ---------------- read path ----------------
    rd_state_t         rd_state, rd_state_nx;
    logic [ID_W-1:0]   rd_id;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len, rd_beat;
    logic [1:0]        rd_burst;
    logic              rd_bad;
    logic              ar_hs, rd_issue, rd_pop;
    logic [2:0]        rd_occ;

    logic              vld_p1, rd_err_p1, rd_last_p1;
    logic [ID_W-1:0]   rd_id_p1;
    logic [DATA_W-1:0] rd_data_p1;
    rbeat_t            beat_p1, skid0, skid1;
    logic [1:0]        skid_cnt;

    assign ar_hs    = s_arvalid && s_arready;
    assign rd_pop   = s_rvalid && s_rready;
    // Occupancy counts the beat leaving this cycle so a full-rate stream has no bubbles.
    assign rd_occ   = {1'b0, skid_cnt} + {2'b0, vld_p1} - {2'b0, rd_pop};
    assign rd_issue = (rd_state == R_BURST) && (rd_occ < 3'd2);

    always_comb begin
        rd_state_nx = rd_state;
        s_arready   = 1'b0;
        case (rd_state)
            R_IDLE: begin
                s_arready = rst_n;
                if (s_arvalid && rst_n) rd_state_nx = R_BURST;
            end
            R_BURST: if (rd_issue && (rd_beat == rd_len)) rd_state_nx = R_IDLE;
            default: rd_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state   <= R_IDLE;
            rd_id      <= '0;
            rd_addr    <= '0;
            rd_len     <= '0;
            rd_beat    <= '0;
            rd_burst   <= '0;
            rd_bad     <= 1'b0;
            vld_p1     <= 1'b0;
            rd_err_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
            rd_id_p1   <= '0;
        end else begin
            rd_state <= rd_state_nx;
            if (ar_hs) begin
                rd_id    <= s_arid;
                rd_addr  <= s_araddr;
                rd_len   <= s_arlen;
                rd_beat  <= '0;
                rd_burst <= s_arburst;
                rd_bad   <= burst_bad(s_arburst, s_arsize);
            end else if (rd_issue) begin
                rd_addr <= next_addr(rd_addr, rd_burst);
                rd_beat <= rd_beat + 8'd1;
            end
            // stage p1: memory read in flight
            vld_p1     <= rd_issue;
            rd_err_p1  <= rd_bad || addr_oor(rd_addr);
            rd_last_p1 <= (rd_beat == rd_len);
            rd_id_p1   <= rd_id;
        end
    end

    always_ff @(posedge clk) begin
        rd_data_p1 <= mem[addr_idx(rd_addr)];
    end

    assign beat_p1.id   = rd_id_p1;
    assign beat_p1.resp = rd_err_p1 ? 2'b10 : 2'b00;
    assign beat_p1.last = rd_last_p1;
    assign beat_p1.data = rd_err_p1 ? '0 : rd_data_p1;

    // stage p2: two-entry skid buffer, skid0 is the presented beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid0    <= '0;
            skid1    <= '0;
            skid_cnt <= '0;
        end else begin
            case ({vld_p1, rd_pop})
                2'b10: begin
                    if (skid_cnt == 2'd0) skid0 <= beat_p1;
                    else                  skid1 <= beat_p1;
                    skid_cnt <= skid_cnt + 2'd1;
                end
                2'b01: begin
                    skid0    <= skid1;
                    skid_cnt <= skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt == 2'd1) begin
                        skid0 <= beat_p1;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= beat_p1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_rvalid = (skid_cnt != 2'd0);
    assign s_rid    = skid0.id;
    assign s_rresp  = skid0.resp;
    assign s_rlast  = skid0.last;
    assign s_rdata  = skid0.data;

    // ---------------- write path ----------------
    wr_state_t         wr_state, wr_state_nx;
    logic [ID_W-1:0]   wr_id;
    logic [ADDR_W-1:0] wr_addr, wr_start;
    logic [7:0]        wr_len, wr_beat;
    logic [1:0]        wr_burst;
    logic              wr_bad, wr_err;
    logic              aw_hs, w_hs, b_hs, w_beat_err, w_last_beat;

    assign aw_hs       = s_awvalid && s_awready;
    assign w_hs        = s_wvalid && s_wready;
    assign b_hs        = s_bvalid && s_bready;
    assign w_beat_err  = wr_bad || addr_oor(wr_addr);
    assign w_last_beat = (wr_beat == wr_len);

    always_comb begin
        wr_state_nx = wr_state;
        s_awready   = 1'b0;
        s_wready    = 1'b0;
        s_bvalid    = 1'b0;
        s_bresp     = 2'b00;
        case (wr_state)
            W_IDLE: begin
                s_awready = rst_n;
                if (s_awvalid && rst_n) wr_state_nx = W_DATA;
            end
            W_DATA: begin
                s_wready = 1'b1;
                if (s_wvalid && w_last_beat) wr_state_nx = W_RESP;
            end
            W_RESP: begin
                s_bvalid = 1'b1;
                s_bresp  = wr_err ? 2'b10 : 2'b00;
                if (s_bready) wr_state_nx = W_IDLE;
            end
            default: wr_state_nx = W_IDLE;
        endcase
    end

    assign s_bid = wr_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state     <= W_IDLE;
            wr_id        <= '0;
            wr_addr      <= '0;
            wr_start     <= '0;
            wr_len       <= '0;
            wr_beat      <= '0;
            wr_burst     <= '0;
            wr_bad       <= 1'b0;
            wr_err       <= 1'b0;
            wr_done      <= 1'b0;
            wr_done_addr <= '0;
            wr_done_err  <= 1'b0;
        end else begin
            wr_state <= wr_state_nx;
            wr_done  <= b_hs;
            if (aw_hs) begin
                wr_id    <= s_awid;
                wr_addr  <= s_awaddr;
                wr_start <= s_awaddr;
                wr_len   <= s_awlen;
                wr_beat  <= '0;
                wr_burst <= s_awburst;
                wr_bad   <= burst_bad(s_awburst, s_awsize);
                wr_err   <= 1'b0;
            end else if (w_hs) begin
                wr_addr <= next_addr(wr_addr, wr_burst);
                wr_beat <= wr_beat + 8'd1;
                wr_err  <= wr_err || w_beat_err || (s_wlast != w_last_beat);
            end
            if (b_hs) begin
                wr_done_addr <= wr_start;
                wr_done_err  <= wr_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs && !w_beat_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_wstrb[b]) mem[addr_idx(wr_addr)][b*8 +: 8] <= s_wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_nvme_dma_axi_responder.sv
// Randomized and directed bench for nvme_dma_axi_responder against a byte-level memory model.
module tb_nvme_dma_axi_responder;
    localparam int          ADDR_W = 32;
    localparam int          DATA_W = 256;
    localparam int          ID_W   = 4;
    localparam int          DEPTH  = 1024;
    localparam logic [31:0] BASE   = 32'h0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [ID_W-1:0]   s_arid = '0, s_awid = '0;
    logic [ADDR_W-1:0] s_araddr = '0, s_awaddr = '0;
    logic [7:0]        s_arlen = '0, s_awlen = '0;
    logic [2:0]        s_arsize = 3'd5, s_awsize = 3'd5;
    logic [1:0]        s_arburst = 2'b01, s_awburst = 2'b01;
    logic              s_arvalid = 1'b0, s_awvalid = 1'b0, s_rready = 1'b0;
    logic [DATA_W-1:0] s_wdata = '0;
    logic [31:0]       s_wstrb = '0;
    logic              s_wlast = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0;
    logic              s_arready, s_rlast, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [ID_W-1:0]   s_rid, s_bid;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp, s_bresp;
    logic              wr_done, wr_done_err;
    logic [ADDR_W-1:0] wr_done_addr;

    nvme_dma_axi_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
                             .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .oculink_0a_axi_aclk(clk), .oculink_0a_axi_rstn(rst_n),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
        .s_bready(s_bready), .wr_done(wr_done), .wr_done_addr(wr_done_addr),
        .wr_done_err(wr_done_err)
    );

    int checks = 0;
    int errors = 0;
    logic [255:0] mdl [DEPTH];
    logic [255:0] wd [256];
    logic [31:0]  ws [256];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic berr(input logic [31:0] a, input logic [1:0] burst, input logic [2:0] size);
        return burst[1] || (size != 3'd5) || (a < BASE) || (((a - BASE) >> 5) >= DEPTH);
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
        return (burst == 2'b01) ? a + 32'(32 * i) : a;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                             input logic [2:0] size, input logic [3:0] id, input int abort_at,
                             input logic bad_wlast, input string tag);
        int t;
        logic err;
        logic [31:0] a;
        logic [9:0] idx;
        @(negedge clk);
        s_awid = id; s_awaddr = addr; s_awlen = 8'(len); s_awsize = size; s_awburst = burst;
        s_awvalid = 1'b1;
        t = 0;
        while (!s_awready && t < 50) begin @(negedge clk); t++; end
        chk({tag, " aw_wait"}, 256'(t < 50), 256'(1));
        @(negedge clk);
        s_awvalid = 1'b0;
        chk({tag, " wready_after_aw"}, 256'(s_wready), 256'(1));
        err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            s_wdata = wd[i]; s_wstrb = ws[i];
            s_wlast = bad_wlast ? 1'b0 : (i == len);
            s_wvalid = 1'b1;
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                s_wvalid = 1'b0;
                return;
            end
            t = 0;
            while (!s_wready && t < 50) begin @(negedge clk); t++; end
            chk({tag, " w_wait"}, 256'(t < 50), 256'(1));
            a = beat_addr(addr, burst, i);
            if (berr(a, burst, size)) begin
                err = 1'b1;
            end else begin
                idx = 10'((a - BASE) >> 5);
                for (int b = 0; b < 32; b++) if (ws[i][b]) mdl[idx][b*8 +: 8] = wd[i][b*8 +: 8];
            end
            @(negedge clk);
        end
        if (bad_wlast) err = 1'b1;
        s_wvalid = 1'b0; s_wlast = 1'b0;
        chk({tag, " bvalid"}, 256'(s_bvalid), 256'(1));
        chk({tag, " wr_done_early"}, 256'(wr_done), 256'(0));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        s_bready = 1'b1;
        chk({tag, " bresp"}, 256'(s_bresp), 256'(err ? 2'b10 : 2'b00));
        chk({tag, " bid"}, 256'(s_bid), 256'(id));
        @(negedge clk);
        s_bready = 1'b0;
        chk({tag, " wr_done"}, 256'(wr_done), 256'(1));
        chk({tag, " wr_done_addr"}, 256'(wr_done_addr), 256'(addr));
        chk({tag, " wr_done_err"}, 256'(wr_done_err), 256'(err));
        chk({tag, " awready_after_b"}, 256'(s_awready), 256'(1));
    endtask

    task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [3:0] id, input int mode,
                            input string tag);
        int t, lat, i, cyc;
        logic stalled, rr, e;
        logic [255:0] sd;
        logic [1:0] sr;
        logic sl;
        logic [31:0] a;
        @(negedge clk);
        s_arid = id; s_araddr = addr; s_arlen = 8'(len); s_arsize = size; s_arburst = burst;
        s_arvalid = 1'b1;
        t = 0;
        while (!s_arready && t < 50) begin @(negedge clk); t++; end
        chk({tag, " ar_wait"}, 256'(t < 50), 256'(1));
        @(negedge clk);
        s_arvalid = 1'b0;
        lat = 0;
        while (!s_rvalid && lat < 20) begin @(negedge clk); lat++; end
        chk({tag, " latency"}, 256'(lat), 256'(2));
        i = 0; cyc = 0; stalled = 1'b0; sd = '0; sr = '0; sl = 1'b0;
        while (i <= len && cyc < 3000) begin
            if (stalled) begin
                chk({tag, " hold_data"}, s_rdata, sd);
                chk({tag, " hold_resp"}, 256'({s_rresp, s_rlast}), 256'({sr, sl}));
            end
            rr = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            s_rready = rr;
            if (s_rvalid && rr) begin
                a = beat_addr(addr, burst, i);
                e = berr(a, burst, size);
                chk($sformatf("%s rdata[%0d]", tag, i), s_rdata, e ? '0 : mdl[10'((a - BASE) >> 5)]);
                chk($sformatf("%s rresp[%0d]", tag, i), 256'(s_rresp), 256'(e ? 2'b10 : 2'b00));
                chk($sformatf("%s rlast[%0d]", tag, i), 256'(s_rlast), 256'(i == len));
                chk($sformatf("%s rid[%0d]", tag, i), 256'(s_rid), 256'(id));
                i++;
                stalled = 1'b0;
            end else if (s_rvalid) begin
                stalled = 1'b1; sd = s_rdata; sr = s_rresp; sl = s_rlast;
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        s_rready = 1'b0;
        chk({tag, " beats"}, 256'(i), 256'(len + 1));
        if (mode == 0) chk({tag, " no_bubbles"}, 256'(cyc), 256'(len + 1));
        chk({tag, " rvalid_after"}, 256'(s_rvalid), 256'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " arready"}, 256'(s_arready), 256'(0));
        chk({tag, " awready"}, 256'(s_awready), 256'(0));
        chk({tag, " wready"}, 256'(s_wready), 256'(0));
        chk({tag, " rvalid"}, 256'(s_rvalid), 256'(0));
        chk({tag, " bvalid"}, 256'(s_bvalid), 256'(0));
        chk({tag, " rdata"}, s_rdata, '0);
        chk({tag, " r_misc"}, 256'({s_rresp, s_rid, s_rlast}), 256'(0));
        chk({tag, " b_misc"}, 256'({s_bresp, s_bid}), 256'(0));
        chk({tag, " wr_done"}, 256'({wr_done, wr_done_err, wr_done_addr}), 256'(0));
    endtask

    initial begin
        logic [31:0] ra;
        logic [1:0]  rb;
        logic [2:0]  rs;
        int          rl, sel;

        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        #1;
        chk("por arready", 256'(s_arready), 256'(1));
        chk("por awready", 256'(s_awready), 256'(1));

        // Fill memory so every model word is defined.
        for (int k = 0; k < DEPTH / 256; k++) begin
            for (int i = 0; i < 256; i++) begin wd[i] = rand256(); ws[i] = '1; end
            axi_write(BASE + 32'(k * 8192), 255, 2'b01, 3'd5, 4'(k), -1, 1'b0, "fill");
        end

        wd[0] = {32{8'hA5}}; ws[0] = '1;
        axi_write(32'h40, 0, 2'b01, 3'd5, 4'h3, -1, 1'b0, "single");
        axi_read(32'h40, 0, 2'b01, 3'd5, 4'h3, 0, "single_rd");

        for (int i = 0; i < 16; i++) begin wd[i] = rand256(); ws[i] = '1; end
        axi_write(32'h1000, 15, 2'b01, 3'd5, 4'h5, -1, 1'b0, "incr16");
        axi_read(32'h1000, 15, 2'b01, 3'd5, 4'h6, 1, "incr16_rd");

        wd[0] = '1; ws[0] = '1;
        axi_write(32'h300, 0, 2'b01, 3'd5, 4'h1, -1, 1'b0, "strb_pre");
        wd[0] = '0; ws[0] = 32'h0000_000F;
        axi_write(32'h300, 0, 2'b01, 3'd5, 4'h1, -1, 1'b0, "strb");
        axi_read(32'h300, 0, 2'b01, 3'd5, 4'h1, 0, "strb_rd");
        chk("strb_model", mdl[24], {{224{1'b1}}, 32'h0});

        axi_read(32'h7FE0, 3, 2'b01, 3'd5, 4'h9, 0, "edge_rd");

        for (int i = 0; i < 4; i++) begin wd[i] = rand256(); ws[i] = '1; end
        axi_write(32'h500, 3, 2'b10, 3'd5, 4'h2, -1, 1'b0, "wrap_wr");
        axi_read(32'h500, 3, 2'b01, 3'd5, 4'h2, 0, "wrap_chk");
        axi_write(32'h600, 1, 2'b01, 3'd4, 4'h4, -1, 1'b0, "size4_wr");
        axi_read(32'h600, 1, 2'b01, 3'd5, 4'h4, 2, "size4_chk");
        axi_read(32'h600, 2, 2'b10, 3'd5, 4'h7, 0, "wrap_rd");
        axi_write(32'h800, 1, 2'b01, 3'd5, 4'h8, -1, 1'b1, "bad_wlast");

        for (int i = 0; i < 8; i++) begin wd[i] = rand256(); ws[i] = '1; end
        axi_write(32'h2000, 7, 2'b01, 3'd5, 4'hA, 5, 1'b0, "rst");
        chk_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel awready", 256'(s_awready), 256'(1));
        chk("rel arready", 256'(s_arready), 256'(1));
        axi_read(32'h2000, 7, 2'b01, 3'd5, 4'hB, 0, "rst_rd");

        for (int n = 0; n < 40; n++) begin
            ra  = BASE + 32'($urandom_range(0, DEPTH + 40) * 32) + 32'($urandom_range(0, 31));
            rl  = $urandom_range(0, 15);
            sel = $urandom_range(0, 9);
            rb  = (sel < 5) ? 2'b01 : (sel < 8) ? 2'b00 : (sel == 8) ? 2'b10 : 2'b11;
            rs  = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'd5;
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= rl; i++) begin wd[i] = rand256(); ws[i] = $urandom(); end
                axi_write(ra, rl, rb, rs, 4'($urandom), -1, 1'b0, "rnd_wr");
            end else begin
                axi_read(ra, rl, rb, rs, 4'($urandom), 2, "rnd_rd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nvme_dma_axi_responder.md
# nvme_dma_axi_responder

AXI4 slave that answers the NVMe SSD's bus-master traffic arriving from the oculink_0a root-port bridge master AXI port (SQ entry fetches, CQ entry posts, PRP data). It sits in the kernel, on the oculink_0a_m_axi side, and is backed by an internal 256-bit-wide memory. Each completed write burst raises a one-cycle notification so kernel logic can detect CQ posts without polling.

## Interface
Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 256, AXI data width; fixed, one word = 32 bytes
- ID_W, 4, AXI ID width
- DEPTH, 1024, memory depth in 256-bit words; power of two
- BASE_ADDR, 32'h0000_0000, byte address of word 0; 32-byte aligned

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - oculink_0a_axi_aclk  in  1  clock
  - oculink_0a_axi_rstn  in  1  asynchronous active-low reset
- Read address channel:
  - s_arid  in  ID_W
  - s_araddr  in  ADDR_W
  - s_arlen  in  8
  - s_arsize  in  3
  - s_arburst  in  2
  - s_arvalid  in  1
  - s_arready  out  1
- Read data channel:
  - s_rid  out  ID_W
  - s_rdata  out  DATA_W
  - s_rresp  out  2
  - s_rlast  out  1
  - s_rvalid  out  1
  - s_rready  in  1
- Write address channel:
  - s_awid  in  ID_W
  - s_awaddr  in  ADDR_W
  - s_awlen  in  8
  - s_awsize  in  3
  - s_awburst  in  2
  - s_awvalid  in  1
  - s_awready  out  1
- Write data channel:
  - s_wdata  in  DATA_W
  - s_wstrb  in  DATA_W/8
  - s_wlast  in  1
  - s_wvalid  in  1
  - s_wready  out  1
- Write response channel:
  - s_bid  out  ID_W
  - s_bresp  out  2
  - s_bvalid  out  1
  - s_bready  in  1
- Write-done notification:
  - wr_done  out  1  one-cycle pulse on B handshake
  - wr_done_addr  out  ADDR_W  start address of the completed burst
  - wr_done_err  out  1  the burst's bresp was SLVERR

## Operation
- Memory is dual-port: one read port, one write port. The read and write paths are fully independent.
- Word index = (addr − BASE_ADDR) >> 5. The low 5 address bits are ignored.
- A beat is out of range when addr < BASE_ADDR or word index ≥ DEPTH.
- Burst types:
  - INCR (01): address advances 32 bytes per beat.
  - FIXED (00): address is constant for all beats.
  - WRAP (10) and reserved (11): every beat gets SLVERR; reads return zero data; writes are dropped.
- Size: axsize ≠ 5 is treated the same as an illegal burst (SLVERR, zero data, writes dropped).
- The beat count is axlen+1 (1..256) in all cases. Responses are never truncated.
- Read FSM, R_IDLE → R_BURST:
  - arready=1 only in R_IDLE. The AR handshake latches id, address, len and error status.
  - Memory reads are issued into a 2-entry output skid buffer. A read is issued only when (buffered + in-flight) < 2.
  - rresp is per beat: OKAY (00), or SLVERR (10) with rdata=0.
  - rlast is on beat axlen. When the last beat is issued, the FSM returns to R_IDLE. The next AR may be accepted while the buffer is still draining.
- Write FSM, W_IDLE → W_DATA → W_RESP → W_IDLE:
  - awready=1 only in W_IDLE. wready=1 only in W_DATA. W data presented before AW is not accepted.
  - On each W handshake, bytes with wstrb=1 are written at the clock edge, unless the beat is in error.
  - A sticky error flag is set by any erroneous beat.
  - wlast is ignored. The burst ends on beat awlen+1. A mismatched wlast sets the error flag.
  - In W_RESP: bvalid=1 and bresp = error flag ? SLVERR : OKAY. On the B handshake: wr_done pulses, then the FSM returns to W_IDLE.
- Same-cycle read and write to the same word: the read returns old data (read-first).

## Timing
- Reset state: all valids and readies are 0. rdata, rresp, rid, bid, bresp and wr_done_addr are 0. rlast, wr_done and wr_done_err are 0. FSMs are IDLE and the skid buffer is empty. Memory contents are not reset.
- First cycle after reset deassertion: arready=1 and awready=1.
- Reset asserted mid-burst: immediate return to the reset state. The partial burst is abandoned; already-written beats remain in memory.
- AR handshake at edge T → first rvalid visible after edge T+2.
- With rready held high: one beat per cycle, no bubbles.
- While rvalid=1 and rready=0, rdata, rresp, rid and rlast hold stable.
- AW handshake at edge T → wready=1 after T.
- Final W beat at edge T → bvalid=1 after T. wr_done is high for the cycle following the B handshake.
- Next AW is accepted at the earliest one cycle after the B handshake.

## Test plan
- Write one beat to 0x40 (awlen=0, wstrb all ones, data 0x…A5), then read it back → bresp=00, wr_done=1 with wr_done_addr=0x40; read returns the same data with rresp=00 and rlast=1, and rvalid appears exactly 2 cycles after the AR handshake.
- Write an INCR burst of 16 beats at 0x1000, then read it back with rready toggling 1/0 every cycle → 16 beats returned in order, data held stable during every stall, rlast only on beat 15.
- Partial strobe: wstrb=0x0000_000F over prior content 0xFF…FF with data 0 → read returns the low 4 bytes as 0 and all other bytes as 0xFF.
- Read with DEPTH=1024 at address 0x7FE0, arlen=3 → beat 0 returns OKAY with data; beats 1–3 return SLVERR with data 0; rlast on beat 3.
- Write with arburst/awburst=WRAP, or awsize=4 → all beats accepted, memory unchanged, bresp=10, wr_done_err=1.
- Assert reset during beat 5 of an 8-beat write → all outputs return to reset values; after release awready=1 and beats 0–4 are retained in memory.
